// File: rtl/video_mem_arbiter.sv
// Arbitrates the VRAM and OAM ports between the CPU, the PPU fetcher and the OAM DMA engine.
// Also applies PPU-mode lockout to CPU accesses and steers read data back to whoever issued the read.
module video_mem_arbiter #(
  parameter int unsigned DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  input  logic        lcd_en,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        dma_src_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_src_data,
  output logic        dma_active,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_rd,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata
);

  localparam logic [15:0] OAM_END     = OAM_BASE + 16'(DMA_LEN);
  localparam logic [7:0]  OAM_BASE_LO = OAM_BASE[7:0];
  localparam logic [7:0]  LAST        = 8'(DMA_LEN - 1);
  localparam logic [15:0] DMA_REG     = 16'hFF46;

  typedef enum logic [1:0] {SEL_NONE, SEL_VRAM, SEL_OAM, SEL_FF} sel_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dma_st_t;

  dma_st_t    st, st_nxt;
  logic [7:0] idx, src_hi;
  logic       wr_vld;
  sel_t       cpu_sel, cpu_sel_nxt, ppu_sel, ppu_sel_nxt;
  logic [7:0] cpu_hold, ppu_hold;

  logic cpu_acc, cpu_in_vram, cpu_in_oam, ppu_in_vram, ppu_in_oam, dma_start;
  logic ppu_vram, ppu_oam, vram_lock, oam_lock, cpu_vram_ok, cpu_oam_ok, dma_oam_wr;

  // Address decode and lockout
  assign cpu_acc     = !rst && (cpu_rd || cpu_wr);
  assign cpu_in_vram = cpu_addr[15:13] == 3'b100;
  assign cpu_in_oam  = (cpu_addr >= OAM_BASE) && (cpu_addr < OAM_END);
  assign ppu_in_vram = ppu_addr[15:13] == 3'b100;
  assign ppu_in_oam  = (ppu_addr >= OAM_BASE) && (ppu_addr < OAM_END);
  assign dma_start   = !rst && cpu_wr && (cpu_addr == DMA_REG);
  assign ppu_vram    = !rst && lcd_en && ppu_rd && ppu_in_vram;
  assign ppu_oam     = !rst && lcd_en && ppu_rd && ppu_in_oam;
  assign vram_lock   = lcd_en && (ppu_mode == 2'd3);
  assign oam_lock    = (lcd_en && ppu_mode[1]) || dma_active || dma_start;
  assign cpu_vram_ok = cpu_acc && cpu_in_vram && !vram_lock;
  assign cpu_oam_ok  = cpu_acc && cpu_in_oam && !oam_lock;
  assign cpu_wait    = (cpu_vram_ok && ppu_vram) || (cpu_oam_ok && ppu_oam);

  // DMA FSM
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (dma_start) st_nxt = RUN;
      RUN:     if (dma_start) st_nxt = RUN;
               else if (idx == LAST) st_nxt = DRAIN;
      DRAIN:   st_nxt = dma_start ? RUN : IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    dma_active   = (st != IDLE);
    dma_src_rd   = !rst && (st == RUN);
    dma_src_addr = dma_src_rd ? {src_hi, idx} : 16'h0000;
    dma_oam_wr   = !rst && (((st == RUN) && wr_vld) || (st == DRAIN));
  end

  // wr_vld marks that last cycle issued a source read; clearing it on restart drops the stale byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 8'h00;
      src_hi <= 8'h00;
      wr_vld <= 1'b0;
    end else if (dma_start) begin
      src_hi <= (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
      idx    <= 8'h00;
      wr_vld <= 1'b0;
    end else if (st == RUN) begin
      idx    <= idx + 8'd1;
      wr_vld <= 1'b1;
    end else begin
      wr_vld <= 1'b0;
    end
  end

  // VRAM port: PPU over CPU
  always_comb begin
    vram_addr  = 13'h0000;
    vram_rd    = 1'b0;
    vram_wr    = 1'b0;
    vram_wdata = 8'h00;
    if (ppu_vram) begin
      vram_addr = ppu_addr[12:0];
      vram_rd   = 1'b1;
    end else if (cpu_vram_ok) begin
      vram_addr  = cpu_addr[12:0];
      vram_rd    = cpu_rd && !cpu_wr;
      vram_wr    = cpu_wr;
      vram_wdata = cpu_wdata;
    end
  end

  // OAM port: DMA over PPU over CPU
  always_comb begin
    oam_addr  = 8'h00;
    oam_rd    = 1'b0;
    oam_wr    = 1'b0;
    oam_wdata = 8'h00;
    if (dma_oam_wr) begin
      oam_addr  = idx - 8'd1;
      oam_wr    = 1'b1;
      oam_wdata = dma_src_data;
    end else if (ppu_oam && !dma_active) begin
      oam_addr = ppu_addr[7:0] - OAM_BASE_LO;
      oam_rd   = 1'b1;
    end else if (cpu_oam_ok) begin
      oam_addr  = cpu_addr[7:0] - OAM_BASE_LO;
      oam_rd    = cpu_rd && !cpu_wr;
      oam_wr    = cpu_wr;
      oam_wdata = cpu_wdata;
    end
  end

  // Read steering: remember where each requester's data comes from next cycle
  always_comb begin
    cpu_sel_nxt = SEL_NONE;
    if (cpu_rd && !rst && !cpu_wait) begin
      if (cpu_vram_ok && !cpu_wr)     cpu_sel_nxt = SEL_VRAM;
      else if (cpu_oam_ok && !cpu_wr) cpu_sel_nxt = SEL_OAM;
      else                            cpu_sel_nxt = SEL_FF;
    end
    ppu_sel_nxt = SEL_NONE;
    if (ppu_vram)     ppu_sel_nxt = SEL_VRAM;
    else if (ppu_oam) ppu_sel_nxt = dma_active ? SEL_FF : SEL_OAM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_sel  <= SEL_NONE;
      ppu_sel  <= SEL_NONE;
      cpu_hold <= 8'hFF;
      ppu_hold <= 8'hFF;
    end else begin
      cpu_sel  <= cpu_sel_nxt;
      ppu_sel  <= ppu_sel_nxt;
      cpu_hold <= cpu_rdata;
      ppu_hold <= ppu_rdata;
    end
  end

  always_comb begin
    case (cpu_sel)
      SEL_VRAM: cpu_rdata = vram_rdata;
      SEL_OAM:  cpu_rdata = oam_rdata;
      SEL_FF:   cpu_rdata = 8'hFF;
      default:  cpu_rdata = cpu_hold;
    endcase
    case (ppu_sel)
      SEL_VRAM: ppu_rdata = vram_rdata;
      SEL_OAM:  ppu_rdata = oam_rdata;
      SEL_FF:   ppu_rdata = 8'hFF;
      default:  ppu_rdata = ppu_hold;
    endcase
  end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Bench for video_mem_arbiter: RAM/source models, a shadow-memory reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_video_mem_arbiter;
  localparam int DMA_LEN = 160;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr = '0, ppu_addr = '0;
  logic        cpu_rd = 0, cpu_wr = 0, lcd_en = 0, ppu_rd = 0;
  logic [7:0]  cpu_wdata = '0;
  logic [1:0]  ppu_mode = '0;
  logic [7:0]  cpu_rdata, ppu_rdata, dma_src_data, vram_wdata, vram_rdata, oam_addr, oam_wdata, oam_rdata;
  logic        cpu_wait, dma_src_rd, dma_active, vram_rd, vram_wr, oam_rd, oam_wr;
  logic [15:0] dma_src_addr;
  logic [12:0] vram_addr;

  video_mem_arbiter #(.DMA_LEN(DMA_LEN), .OAM_BASE(16'hFE00)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait), .lcd_en(lcd_en),
    .ppu_mode(ppu_mode), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .dma_src_rd(dma_src_rd), .dma_src_addr(dma_src_addr), .dma_src_data(dma_src_data),
    .dma_active(dma_active), .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .oam_addr(oam_addr), .oam_rd(oam_rd),
    .oam_wr(oam_wr), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata));

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Source memory content: for page C1 this is i^3C
  function automatic logic [7:0] src_f(input logic [15:0] a);
    return a[7:0] ^ 8'h3C ^ a[15:8] ^ 8'hC1;
  endfunction

  // RAM and source-bus models, 1-cycle read latency
  logic [7:0] vmem [8192];
  logic [7:0] omem [256];
  logic [7:0] vq = 8'h00, oq = 8'h00, sq = 8'h00;
  assign vram_rdata = vq;
  assign oam_rdata = oq;
  assign dma_src_data = sq;
  always @(posedge clk) begin
    if (vram_wr) vmem[vram_addr] <= vram_wdata;
    if (vram_rd) vq <= vmem[vram_addr];
    if (oam_wr) omem[oam_addr] <= oam_wdata;
    if (oam_rd) oq <= omem[oam_addr];
    if (dma_src_rd) sq <= src_f(dma_src_addr);
  end

  // Reference model: shadow memories plus DMA as a position counter 0..DMA_LEN
  logic [7:0] sh_vram [8192];
  logic [7:0] sh_oam [256];
  logic [7:0] exp_cpu = 8'hFF, exp_ppu = 8'hFF, hi_m = 8'h00;
  bit act_m = 0;
  int pos_m = 0;

  function automatic bit in_vram(input logic [15:0] a); return a >= 16'h8000 && a <= 16'h9FFF; endfunction
  function automatic bit in_oam(input logic [15:0] a);  return a >= 16'hFE00 && a <= 16'hFE9F; endfunction
  function automatic bit m_cpu_vram();
    return (cpu_rd || cpu_wr) && in_vram(cpu_addr) && !(lcd_en && ppu_mode == 2'd3);
  endfunction
  function automatic bit m_cpu_oam();
    return (cpu_rd || cpu_wr) && in_oam(cpu_addr) && !(lcd_en && ppu_mode >= 2'd2) && !act_m;
  endfunction
  function automatic bit m_wait();
    return (m_cpu_vram() && lcd_en && ppu_rd && in_vram(ppu_addr)) ||
           (m_cpu_oam() && lcd_en && ppu_rd && in_oam(ppu_addr));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_cpu <= 8'hFF;
      exp_ppu <= 8'hFF;
      act_m   <= 0;
    end else begin
      if (cpu_rd && !m_wait()) begin
        if (m_cpu_vram())     exp_cpu <= sh_vram[cpu_addr[12:0]];
        else if (m_cpu_oam()) exp_cpu <= sh_oam[cpu_addr[7:0]];
        else                  exp_cpu <= 8'hFF;
      end
      if (lcd_en && ppu_rd) begin
        if (in_vram(ppu_addr))     exp_ppu <= sh_vram[ppu_addr[12:0]];
        else if (in_oam(ppu_addr)) exp_ppu <= act_m ? 8'hFF : sh_oam[ppu_addr[7:0]];
      end
      if (cpu_wr && !cpu_rd && !m_wait()) begin
        if (m_cpu_vram())     sh_vram[cpu_addr[12:0]] <= cpu_wdata;
        else if (m_cpu_oam()) sh_oam[cpu_addr[7:0]] <= cpu_wdata;
      end
      if (act_m && pos_m >= 1) sh_oam[8'(pos_m - 1)] <= src_f({hi_m, 8'(pos_m - 1)});
      if (cpu_wr && cpu_addr == 16'hFF46) begin
        act_m <= 1;
        pos_m <= 0;
        hi_m  <= (cpu_wdata >= 8'hE0) ? cpu_wdata - 8'h20 : cpu_wdata;
      end else if (act_m) begin
        pos_m <= pos_m + 1;
        if (pos_m == DMA_LEN) act_m <= 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cpu_rdata", cpu_rdata, exp_cpu);
      chk("ppu_rdata", ppu_rdata, exp_ppu);
      chk("dma_active", dma_active, act_m);
      chk("cpu_wait", cpu_wait, m_wait());
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic cpu_set(input bit wr, input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wr = wr; cpu_rd = !wr; cpu_wdata = d;
  endtask
  task automatic cpu_clr(); cpu_rd = 0; cpu_wr = 0; endtask

  // Follows a DMA already requested this cycle until dma_active drops
  task automatic dma_watch(input bit probe, input int rs_at, input logic [7:0] rs_v,
                           output int cyc, output logic [15:0] first, output logic [15:0] last,
                           output logic [15:0] rs_first);
    bit seen = 0, done = 0, rs_done = 0;
    int pr = 0, rs_n = 0;
    cyc = 0; first = '0; last = '0; rs_first = '0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (pr == 2) begin
        chk("dma_cpu_oam_rd", cpu_rdata, 8'hFF);
        chk("dma_ppu_oam_rd", ppu_rdata, 8'hFF);
        pr = 3;
      end
      if (dma_active) cyc++;
      if (dma_src_rd) begin
        if (!seen) first = dma_src_addr;
        seen = 1;
        if (rs_done) begin
          rs_n++;
          if (rs_n == 2) rs_first = dma_src_addr;
        end
        last = dma_src_addr;
      end
      if (seen && !dma_active) done = 1;
      tick();
      cpu_clr(); ppu_rd = 0;
      if (probe && pr == 0 && cyc == 20) begin
        cpu_set(0, 16'hFE10, 8'h00); ppu_rd = 1; ppu_addr = 16'hFE11; pr = 1;
      end else if (pr == 1) pr = 2;
      if (rs_at >= 0 && !rs_done && seen && last[7:0] == 8'(rs_at)) begin
        cpu_set(1, 16'hFF46, rs_v); rs_done = 1;
      end
    end
    if (!done) chk("dma_timeout", 0, 1);
  endtask

  initial begin
    int cyc, bad, nwr;
    logic [15:0] first, last, rsf;
    for (int i = 0; i < 8192; i++) begin vmem[i] = 8'h00; sh_vram[i] = 8'h00; end
    for (int i = 0; i < 256; i++) begin omem[i] = 8'h00; sh_oam[i] = 8'h00; end

    repeat (3) @(posedge clk);
    #1 rst = 0; cmp_en = 1;
    @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_ppu_rdata", ppu_rdata, 8'hFF);
    chk("rst_strobes", {vram_rd, vram_wr, oam_rd, oam_wr, dma_src_rd, dma_active, cpu_wait}, 0);
    chk("rst_addrs", {vram_addr, oam_addr, dma_src_addr}, 0);

    // CPU VRAM write/read with LCD on, HBLANK
    tick(); lcd_en = 1; ppu_mode = 0;
    cpu_set(1, 16'h8010, 8'h5A);
    @(negedge clk);
    chk("vram_wr", {vram_wr, vram_addr, vram_wdata}, {1'b1, 13'h0010, 8'h5A});
    tick(); cpu_clr(); cpu_set(0, 16'h8010, 8'h00);
    @(negedge clk); chk("vram_rd", vram_rd, 1);
    tick(); cpu_clr();
    @(negedge clk); chk("rd_5A", cpu_rdata, 8'h5A);

    // DRAW lockout, OAM lockout in SCAN, no lockout with LCD off
    tick(); ppu_mode = 3; cpu_set(0, 16'h8000, 8'h00);
    @(negedge clk); chk("m3_no_vram_rd", vram_rd, 0);
    tick(); cpu_clr();
    @(negedge clk); chk("m3_rd_ff", cpu_rdata, 8'hFF);
    tick(); cpu_set(1, 16'hFE00, 8'h77);
    @(negedge clk); chk("m3_no_oam_wr", oam_wr, 0);
    tick(); cpu_clr(); ppu_mode = 2; cpu_set(1, 16'h8020, 8'hA5);
    @(negedge clk); chk("m2_vram_wr", vram_wr, 1);
    tick(); cpu_clr(); cpu_set(1, 16'hFE01, 8'h44);
    @(negedge clk); chk("m2_no_oam_wr", oam_wr, 0);
    tick(); cpu_clr(); lcd_en = 0; ppu_mode = 3; cpu_set(1, 16'hFE05, 8'h33);
    @(negedge clk); chk("lcdoff_oam_wr", {oam_wr, oam_addr}, {1'b1, 8'h05});
    tick(); cpu_clr(); ppu_rd = 1; ppu_addr = 16'h8010;
    @(negedge clk); chk("lcdoff_ppu_ignored", vram_rd, 0);
    tick(); ppu_rd = 0; cpu_set(0, 16'hFE05, 8'h00);
    tick(); cpu_clr();
    @(negedge clk); chk("lcdoff_oam_rd", cpu_rdata, 8'h33);
    tick(); cpu_set(0, 16'hC000, 8'h00);
    tick(); cpu_clr();
    @(negedge clk); chk("outside_rd_ff", cpu_rdata, 8'hFF);

    // OAM DMA from C100
    tick(); lcd_en = 1; ppu_mode = 0; cpu_set(1, 16'hFF46, 8'hC1);
    dma_watch(1, -1, 8'h00, cyc, first, last, rsf);
    chk("dma_cycles", cyc, 161);
    chk("dma_first_src", first, 16'hC100);
    chk("dma_last_src", last, 16'hC19F);
    bad = 0;
    for (int i = 0; i < DMA_LEN; i++) if (omem[i] !== (8'(i) ^ 8'h3C)) bad++;
    chk("dma_oam_bytes_bad", bad, 0);
    cpu_set(0, 16'hFE10, 8'h00);
    tick(); cpu_clr();
    @(negedge clk); chk("post_dma_oam_rd", cpu_rdata, 8'h2C);

    // E2 folds down to C2
    tick(); cpu_set(1, 16'hFF46, 8'hE2);
    dma_watch(0, -1, 8'h00, cyc, first, last, rsf);
    chk("dma_e2_first", first, 16'hC200);

    // Restart mid-transfer from D000
    tick(); cpu_set(1, 16'hFF46, 8'hC1);
    dma_watch(0, 50, 8'hD0, cyc, first, last, rsf);
    chk("restart_first", rsf, 16'hD000);
    chk("restart_cycles", cyc, 213);
    chk("restart_last", last, 16'hD09F);
    bad = 0;
    for (int i = 0; i < DMA_LEN; i++) if (omem[i] !== (8'(i) ^ 8'h2D)) bad++;
    chk("restart_oam_bytes_bad", bad, 0);

    // PPU and CPU contend for VRAM in VBLANK
    tick(); ppu_mode = 1; ppu_rd = 1; ppu_addr = 16'h8020; cpu_set(0, 16'h8010, 8'h00);
    @(negedge clk); chk("contend_wait", {cpu_wait, vram_addr}, {1'b1, 13'h0020});
    tick(); ppu_rd = 0;
    @(negedge clk);
    chk("contend_served", {cpu_wait, vram_addr}, {1'b0, 13'h0010});
    chk("contend_ppu_data", ppu_rdata, 8'hA5);
    tick(); cpu_clr();
    @(negedge clk); chk("contend_cpu_data", cpu_rdata, 8'h5A);

    // Reset during DMA
    tick(); ppu_mode = 0; cpu_set(1, 16'hFF46, 8'hC1);
    tick(); cpu_clr();
    repeat (30) tick();
    rst = 1;
    tick(); rst = 0;
    @(negedge clk); chk("rst_mid_dma_active", dma_active, 0);
    nwr = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (oam_wr) nwr++; end
    chk("rst_mid_no_oam_wr", nwr, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
